// File: rtl/call_stack.sv
// call_stack
// ----------
// Return-address LIFO for a CPU. The call path pushes PC+1 and the return
// path pops into the PC mux. Operations are clocked. The top-of-stack view
// is combinational, so the CPU can sample the return address in the same
// cycle that it asserts pop. Overflow and underflow set sticky error flags.
//
// Parameters:
//   WIDTH  bits per entry (PC width)
//   DEPTH  number of entries, >= 2; does not have to be a power of two
//   CW     width of count, $clog2(DEPTH+1)
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-high reset (clears count and flags)
//   push     push din this cycle
//   pop      pop the top entry this cycle (push+pop = replace top)
//   din      data to push
//   clr_err  synchronous clear of ovf/unf; a new error in the same cycle wins
//   top      current top entry, 0 when empty
//   count    number of valid entries, 0..DEPTH
//   empty    count == 0
//   full     count == DEPTH
//   ovf      sticky overflow (push while full)
//   unf      sticky underflow (pop while empty)
module call_stack #(
  parameter  int WIDTH = 10,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  // The index only has to address DEPTH entries; count needs one extra value.
  localparam int IW = $clog2(DEPTH);

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          ovf_q;
  logic          ovf_d;
  logic          unf_q;
  logic          unf_d;

  logic          empty_s;
  logic          full_s;
  logic          wr_en_s;
  logic [IW-1:0] wr_idx_s;
  logic [IW-1:0] top_idx_s;

  assign empty_s = (count_q == CNT_ZERO);
  assign full_s  = (count_q == CNT_FULL);

  // The top index is formed only when the stack holds data. An empty stack
  // therefore never computes count-1 and never wraps it.
  always_comb begin
    top_idx_s = {IW{1'b0}};
    if (!empty_s) begin
      top_idx_s = IW'(count_q - CNT_ONE);
    end else begin
      top_idx_s = {IW{1'b0}};
    end
  end

  // The top-of-stack view reads the array directly from registered state.
  always_comb begin
    top = {WIDTH{1'b0}};
    if (!empty_s) begin
      top = mem_q[top_idx_s];
    end else begin
      top = {WIDTH{1'b0}};
    end
  end

  // Next-state logic for count, the flags and the array write port.
  always_comb begin
    count_d  = count_q;
    wr_en_s  = 1'b0;
    wr_idx_s = {IW{1'b0}};

    // The clear is applied first. An error raised below in the same cycle
    // overrides it, so the new error stays visible.
    if (clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
      unf_d = unf_q;
    end

    case ({push, pop})
      2'b10: begin
        if (!full_s) begin
          wr_en_s  = 1'b1;
          wr_idx_s = IW'(count_q);
          count_d  = count_q + CNT_ONE;
        end else begin
          ovf_d = 1'b1;
        end
      end
      2'b01: begin
        if (!empty_s) begin
          count_d = count_q - CNT_ONE;
        end else begin
          unf_d = 1'b1;
        end
      end
      2'b11: begin
        // Replace the top in place. On an empty stack this acts as a push
        // into slot 0. A replace can never raise an error.
        if (!empty_s) begin
          wr_en_s  = 1'b1;
          wr_idx_s = top_idx_s;
        end else begin
          wr_en_s  = 1'b1;
          wr_idx_s = {IW{1'b0}};
          count_d  = CNT_ONE;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Occupancy and sticky flags; reset wins over any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= CNT_ZERO;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is not reset. A write that lands while reset is asserted is
  // harmless, because count is held at 0 and the entry cannot be reached.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_idx_s] <= din;
    end
  end

  assign count = count_q;
  assign empty = empty_s;
  assign full  = full_s;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_call_stack.sv
// Testbench for call_stack. Two instances share the same stimulus:
//   u8: DEPTH=8, WIDTH=10
//   u5: DEPTH=5, WIDTH=12
// A table of directed vectors carries constant expectations for u8. Both
// instances are also compared against a stack model on every cycle.
module tb_call_stack;

  logic        clk = 1'b0;
  logic        reset;
  logic        push;
  logic        pop;
  logic        clr_err;
  logic [11:0] din;

  logic [9:0]  top8;
  logic [3:0]  cnt8;
  logic        empty8, full8, ovf8, unf8;
  logic [11:0] top5;
  logic [2:0]  cnt5;
  logic        empty5, full5, ovf5, unf5;

  call_stack #(.WIDTH(10), .DEPTH(8)) u8 (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din[9:0]),
    .clr_err(clr_err), .top(top8), .count(cnt8), .empty(empty8),
    .full(full8), .ovf(ovf8), .unf(unf8)
  );

  call_stack #(.WIDTH(12), .DEPTH(5)) u5 (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din),
    .clr_err(clr_err), .top(top5), .count(cnt5), .empty(empty5),
    .full(full5), .ovf(ovf5), .unf(unf5)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: one stack per instance ----------------
  int mstk [2][16];
  int mcnt [2];
  bit movf [2];
  bit munf [2];
  int mdep [2] = '{8, 5};
  int mmask[2] = '{32'h3FF, 32'hFFF};

  function automatic int model_top(input int i);
    return (mcnt[i] > 0) ? mstk[i][mcnt[i]-1] : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mcnt[i] = 0;
      movf[i] = 1'b0;
      munf[i] = 1'b0;
    end
  endtask

  task automatic model_step(input bit p, input bit q, input int d, input bit c);
    for (int i = 0; i < 2; i++) begin
      bit eo = 1'b0;
      bit eu = 1'b0;
      int v  = d & mmask[i];
      if (p && q) begin
        if (mcnt[i] == 0) begin mstk[i][0] = v; mcnt[i] = 1; end
        else mstk[i][mcnt[i]-1] = v;
      end else if (p) begin
        if (mcnt[i] == mdep[i]) eo = 1'b1;
        else begin mstk[i][mcnt[i]] = v; mcnt[i]++; end
      end else if (q) begin
        if (mcnt[i] == 0) eu = 1'b1;
        else mcnt[i]--;
      end
      movf[i] = eo | (movf[i] & !c);
      munf[i] = eu | (munf[i] & !c);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".cnt8"},   32'(cnt8),   mcnt[0]);
    chk({tag, ".top8"},   32'(top8),   model_top(0));
    chk({tag, ".empty8"}, 32'(empty8), 32'(mcnt[0] == 0));
    chk({tag, ".full8"},  32'(full8),  32'(mcnt[0] == 8));
    chk({tag, ".ovf8"},   32'(ovf8),   32'(movf[0]));
    chk({tag, ".unf8"},   32'(unf8),   32'(munf[0]));
    chk({tag, ".cnt5"},   32'(cnt5),   mcnt[1]);
    chk({tag, ".top5"},   32'(top5),   model_top(1));
    chk({tag, ".empty5"}, 32'(empty5), 32'(mcnt[1] == 0));
    chk({tag, ".full5"},  32'(full5),  32'(mcnt[1] == 5));
    chk({tag, ".ovf5"},   32'(ovf5),   32'(movf[1]));
    chk({tag, ".unf5"},   32'(unf5),   32'(munf[1]));
  endtask

  // Drive one cycle. Inputs change at the falling edge. Top is checked
  // before the rising edge (the value a popping CPU would take), and the
  // full state is checked 1ns after the rising edge.
  task automatic step(input bit p, input bit q, input logic [11:0] d, input bit c);
    @(negedge clk);
    push = p; pop = q; din = d; clr_err = c;
    #1;
    chk("pre.top8", 32'(top8), model_top(0));
    chk("pre.top5", 32'(top5), model_top(1));
    @(posedge clk);
    #1;
    model_step(p, q, 32'(d), c);
    check_all("step");
  endtask

  // ---------------- directed vector table (expectations for u8) ----------------
  typedef struct {
    bit          p;
    bit          q;
    bit          c;
    logic [11:0] d;
    int          e_cnt;
    int          e_top;
    bit          e_ovf;
    bit          e_unf;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input bit p, input bit q, input bit c, input logic [11:0] d,
                      input int ec, input int et, input bit eo, input bit eu);
    vec_t v;
    v.p = p; v.q = q; v.c = c; v.d = d;
    v.e_cnt = ec; v.e_top = et; v.e_ovf = eo; v.e_unf = eu;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; din = 12'h000;

    // Test-plan sequences for the 8-deep instance.
    for (int k = 1; k <= 8; k++) addv(1'b1, 1'b0, 1'b0, 12'(k), k, k, 1'b0, 1'b0);
    addv(1'b1, 1'b0, 1'b0, 12'h3FF, 8, 8, 1'b1, 1'b0);   // push while full
    addv(1'b0, 1'b0, 1'b1, 12'h000, 8, 8, 1'b0, 1'b0);   // clear ovf
    for (int k = 7; k >= 0; k--) addv(1'b0, 1'b1, 1'b0, 12'h000, k, k, 1'b0, 1'b0);
    addv(1'b0, 1'b1, 1'b0, 12'h000, 0, 0, 1'b0, 1'b1);   // pop while empty
    addv(1'b0, 1'b1, 1'b1, 12'h000, 0, 0, 1'b0, 1'b1);   // error beats clear
    addv(1'b0, 1'b0, 1'b1, 12'h000, 0, 0, 1'b0, 1'b0);
    addv(1'b1, 1'b0, 1'b0, 12'h010, 1, 12'h010, 1'b0, 1'b0);
    addv(1'b1, 1'b0, 1'b0, 12'h020, 2, 12'h020, 1'b0, 1'b0);
    addv(1'b1, 1'b1, 1'b0, 12'h0AA, 2, 12'h0AA, 1'b0, 1'b0); // replace
    addv(1'b0, 1'b1, 1'b0, 12'h000, 1, 12'h010, 1'b0, 1'b0);
    addv(1'b0, 1'b1, 1'b0, 12'h000, 0, 0, 1'b0, 1'b0);
    addv(1'b1, 1'b1, 1'b0, 12'h055, 1, 12'h055, 1'b0, 1'b0); // replace on empty
    addv(1'b0, 1'b1, 1'b0, 12'h000, 0, 0, 1'b0, 1'b0);

    // Reset state; clock edges occur while reset is held.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.cnt8", 32'(cnt8), 32'd0);
    chk("rst.top8", 32'(top8), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst.empty8", 32'(empty8), 32'd1);
    chk("rst.full8",  32'(full8),  32'd0);
    check_all("rst");

    // Table-driven part.
    foreach (vecs[i]) begin
      step(vecs[i].p, vecs[i].q, vecs[i].d, vecs[i].c);
      chk("vec.cnt8", 32'(cnt8), 32'(vecs[i].e_cnt));
      chk("vec.top8", 32'(top8), 32'(vecs[i].e_top));
      chk("vec.ovf8", 32'(ovf8), 32'(vecs[i].e_ovf));
      chk("vec.unf8", 32'(unf8), 32'(vecs[i].e_unf));
    end

    // Asynchronous reset between clock edges. A push held during reset
    // must be discarded.
    step(1'b1, 1'b0, 12'h101, 1'b0);
    step(1'b1, 1'b0, 12'h102, 1'b0);
    step(1'b1, 1'b0, 12'h103, 1'b0);
    chk("ar.pre.cnt8", 32'(cnt8), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("ar.cnt8", 32'(cnt8), 32'd0);
    chk("ar.top8", 32'(top8), 32'd0);
    chk("ar.cnt5", 32'(cnt5), 32'd0);
    @(negedge clk);
    push = 1'b1; pop = 1'b0; din = 12'h3EE; clr_err = 1'b0;
    @(negedge clk);
    reset = 1'b0; push = 1'b0;
    model_reset();
    #1;
    check_all("ar.rel");
    step(1'b1, 1'b0, 12'h123, 1'b0);
    chk("ar.push.top8", 32'(top8), 32'h123);
    chk("ar.push.cnt8", 32'(cnt8), 32'd1);

    // The 5-deep instance saturates at 5; u8 continues in step.
    step(1'b0, 1'b1, 12'h000, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      step(1'b1, 1'b0, 12'(12'hA00 + i), 1'b0);
      chk("d5.cnt5",  32'(cnt5),  32'((i < 5) ? i : 5));
      chk("d5.full5", 32'(full5), 32'(i >= 5));
      chk("d5.ovf5",  32'(ovf5),  32'(i > 5));
    end
    chk("d5.top5", 32'(top5), 32'hA05);
    for (int i = 4; i >= 0; i--) begin
      step(1'b0, 1'b1, 12'h000, 1'b0);
      chk("d5.pop.cnt5", 32'(cnt5), 32'(i));
    end

    // Randomized traffic. Push-heavy and pop-heavy phases alternate so that
    // both saturation limits are reached repeatedly.
    for (int n = 0; n < 3000; n++) begin
      bit ph;
      bit rp;
      bit rq;
      ph = ((n / 150) % 2) == 0;
      rp = $urandom_range(0, 99) < (ph ? 70 : 30);
      rq = $urandom_range(0, 99) < (ph ? 30 : 70);
      step(rp, rq, 12'($urandom_range(0, 4095)), $urandom_range(0, 19) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/call_stack.md
Name: call_stack

Overview:
- Synchronous, parametrised LIFO for CPU subroutine return addresses; successor to the fixed 8-entry, 10-bit stack.
- Sits beside the PC register. The call path pushes PC+1, the return path pops into the PC mux.
- Adds clocked operation, configurable width and depth, a combinational top-of-stack view, simultaneous push/pop (replace), occupancy count, and sticky overflow/underflow error flags.

Parameters:
- WIDTH, 10, bits per entry (PC width).
- DEPTH, 8, number of entries; any integer >= 2, need not be a power of two.
- CW (localparam), $clog2(DEPTH+1), width of count.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- push  input  1  push din this cycle.
- pop  input  1  pop top entry this cycle.
- din  input  WIDTH  data to push.
- clr_err  input  1  synchronous clear of ovf/unf.
- top  output  WIDTH  current top-of-stack entry; 0 when empty.
- count  output  CW  number of valid entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- ovf  output  1  sticky overflow flag.
- unf  output  1  sticky underflow flag.

Behaviour:
- Reset (async, clk not required): count=0, ovf=0, unf=0, so top=0, empty=1, full=0. Storage array is not reset.
- Reset mid-operation: any push/pop in the same cycle is discarded; contents become unreachable.
- Storage: mem[0..DEPTH-1]; entry i is valid for i < count.
- top = mem[count-1] when count>0, else 0. Purely combinational from registered state; no read latency. The CPU samples top in the same cycle it asserts pop.
- Operations by {push,pop}, evaluated at posedge clk:
  - 00: hold.
  - 10, not full: mem[count] <= din; count <= count+1. top shows din from the next cycle.
  - 10, full: ignored; contents/count unchanged; ovf <= 1.
  - 01, not empty: count <= count-1. top shows previous entry next cycle; popped value is top in the cycle of the pop.
  - 01, empty: ignored; unf <= 1.
  - 11, not empty (including full): replace; mem[count-1] <= din; count unchanged; no error.
  - 11, empty: treated as push; mem[0] <= din; count <= 1; no error.
- Flags: ovf/unf stay set until reset or clr_err. clr_err clears both at posedge. If a new error occurs in the same cycle as clr_err, the error wins and its flag reads 1 next cycle.
- No wrap-around: count saturates at 0 and DEPTH; the index never wraps.
- Arithmetic: count is CW bits unsigned; index = count-1 is only evaluated when count>0.
- Implementation: single always block with async reset for count/flags; separate clocked write for mem.

Test Plan:
- Reset then idle -> top=0, count=0, empty=1, full=0, ovf=0, unf=0.
- DEPTH=8, WIDTH=10: push 0x001..0x008 on consecutive cycles -> count=8, full=1, top=0x008; then pop 8 times -> top sequence 0x008..0x001 sampled in each pop cycle, then count=0, empty=1, top=0.
- Full stack, push 0x3FF -> count stays 8, top stays 0x008, ovf=1. Then clr_err one cycle -> ovf=0.
- Empty stack, pop -> count=0, unf=1. Pop again with clr_err asserted in the same cycle -> unf still 1.
- Stack holding 0x010,0x020, push&pop with din=0x0AA -> count=2, top=0x0AA, then pop -> top=0x010. Empty stack push&pop din=0x055 -> count=1, top=0x055, unf=0.
- Push 3 entries, assert reset asynchronously between clock edges -> count=0, top=0 immediately. Release, push 0x123 -> top=0x123, count=1.
- Repeat the full/empty scenarios with DEPTH=5, WIDTH=12 -> full at count=5, and count never exceeds 5.
